// File: rtl/reservoir_pkg.sv
// Shared definitions for the reservoir capture back end: FSM encoding,
// default frame header and a constant-width helper.
package reservoir_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_CAPTURE = 2'd1,
      ST_DRAIN   = 2'd2
   } state_t;

   localparam logic [7:0] DEFAULT_HEADER = 8'hA5;

   function automatic int clog2(input int value);
      int r;
      int v;
      r = 0;
      v = value - 1;
      while (v > 0) begin
         r++;
         v = v >> 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/sample_fifo.sv
// First-word fall-through byte FIFO; a push into a full FIFO succeeds only
// when a pop frees the head slot in the same cycle.
module sample_fifo
   import reservoir_pkg::*;
#(
   parameter int DEPTH = 16,
   parameter int WIDTH = 8
) (
   input  logic             fast_clk,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head,
   output logic             full,
   output logic             empty,
   output logic             dropped
);

   localparam int AW = clog2(DEPTH);

   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic [WIDTH-1:0] mem [DEPTH];
   logic             do_push;
   logic             do_pop;

   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);
   assign dropped = push & full & ~do_pop;

   always_ff @(posedge fast_clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
         if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
      end
   end

   always_ff @(posedge fast_clk) begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
   end

   // Gate the head so an empty (or freshly reset) FIFO presents zero.
   assign head = empty ? '0 : mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/reservoir_sampler.sv
// Captures the reservoir dynamics bit during a run, packs it LSB-first into
// bytes behind a header byte, and streams the bytes out over valid/ready.
//
// state   | meaning
// IDLE    | waiting for a rising edge of collect_dynamics
// CAPTURE | sampling dynamics every SAMPLE_DIV cycles, pushing full bytes
// DRAIN   | all samples taken, waiting for the FIFO to empty
module reservoir_sampler
   import reservoir_pkg::*;
#(
   parameter int          NUM_SAMPLES = 2048,
   parameter int          SAMPLE_DIV  = 1,
   parameter int          FIFO_DEPTH  = 16,
   parameter logic [7:0]  HEADER      = DEFAULT_HEADER
) (
   input  logic       fast_clk,
   input  logic       reset,
   input  logic       collect_dynamics,
   input  logic       dynamics,
   input  logic       tx_ready,
   output logic [7:0] tx_byte,
   output logic       tx_valid,
   output logic       busy,
   output logic       overflow
);

   localparam int CW = clog2(NUM_SAMPLES + 1);
   localparam int DW = clog2(SAMPLE_DIV + 1);
   localparam logic [CW-1:0] ALL_SAMPLES = CW'(NUM_SAMPLES);
   localparam logic [CW-1:0] LAST_SAMPLE = CW'(NUM_SAMPLES - 1);
   localparam logic [DW-1:0] DIV_LAST    = DW'(SAMPLE_DIV - 1);

   state_t          state;
   state_t          state_nxt;
   logic            dyn_meta;
   logic            dyn_sync;
   logic            collect_q;
   logic            rise;
   logic [DW-1:0]   div_cnt;
   logic [CW-1:0]   bit_cnt;
   logic [6:0]      shift_reg;
   logic [7:0]      sample_byte;
   logic            sample_now;
   logic            byte_done;
   logic            last_taken;
   logic            start;
   logic            push;
   logic [7:0]      push_data;
   logic            pop;
   logic            fifo_empty;
   logic            fifo_full;
   logic            fifo_dropped;

   assign rise        = collect_dynamics & ~collect_q;
   assign start       = (state == ST_IDLE) && rise;
   assign sample_now  = (state == ST_CAPTURE) && (div_cnt == '0) && (bit_cnt != ALL_SAMPLES);
   assign sample_byte = {dyn_sync, shift_reg};
   assign byte_done   = sample_now && (bit_cnt[2:0] == 3'd7);
   assign last_taken  = (bit_cnt == ALL_SAMPLES) || (sample_now && (bit_cnt == LAST_SAMPLE));
   assign push        = start | byte_done;
   assign push_data   = start ? HEADER : sample_byte;
   assign pop         = tx_valid & tx_ready;
   assign tx_valid    = ~fifo_empty;
   assign busy        = (state != ST_IDLE);

   always_ff @(posedge fast_clk or posedge reset) begin
      if (reset) state <= ST_IDLE;
      else       state <= state_nxt;
   end

   // Capture ends once the last sample's divider period has fully elapsed.
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:    if (rise) state_nxt = ST_CAPTURE;
         ST_CAPTURE: if (last_taken && (div_cnt == DIV_LAST)) state_nxt = ST_DRAIN;
         ST_DRAIN:   if (fifo_empty) state_nxt = ST_IDLE;
         default:    state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge fast_clk or posedge reset) begin
      if (reset) begin
         dyn_meta  <= 1'b0;
         dyn_sync  <= 1'b0;
         collect_q <= 1'b0;
         div_cnt   <= '0;
         bit_cnt   <= '0;
         shift_reg <= '0;
         overflow  <= 1'b0;
      end else begin
         dyn_meta  <= dynamics;
         dyn_sync  <= dyn_meta;
         collect_q <= collect_dynamics;

         if (start) begin
            div_cnt   <= '0;
            bit_cnt   <= '0;
            shift_reg <= '0;
         end else if (state == ST_CAPTURE) begin
            div_cnt <= (div_cnt == DIV_LAST) ? '0 : div_cnt + DW'(1);
            if (sample_now) begin
               shift_reg <= sample_byte[7:1];
               bit_cnt   <= bit_cnt + CW'(1);
            end
         end

         // A dropped header still flags the new run.
         if (start)             overflow <= fifo_dropped;
         else if (fifo_dropped) overflow <= 1'b1;
      end
   end

   sample_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (8)
   ) u_fifo (
      .fast_clk  (fast_clk),
      .reset     (reset),
      .push      (push),
      .push_data (push_data),
      .pop       (pop),
      .head      (tx_byte),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .dropped   (fifo_dropped)
   );

   logic unused_full;
   assign unused_full = fifo_full;

endmodule

// File: doc/reservoir_sampler.md
Name: reservoir_sampler

Overview:
- Back end of the reservoir run: captures the single-bit `dynamics` output of the delay reservoir during a run window.
- Packs the captured bits into bytes and buffers them in a FIFO.
- Hands the bytes to the UART transmit path over a valid/ready handshake, so the host receives each run's response.
- Sits beside reservoir_controller. `collect_dynamics` from the controller arms a capture. The output feeds the UART TX block.

Parameters:
- NUM_SAMPLES, 2048, number of dynamics bits captured per run; must be a multiple of 8 and ≥ 8.
- SAMPLE_DIV, 1, take one sample every SAMPLE_DIV fast_clk cycles; must be ≥ 1.
- FIFO_DEPTH, 16, byte FIFO entries; must be a power of 2 and ≥ 2.
- HEADER, 8'hA5, frame-start byte pushed ahead of each run's data.

Ports:
- fast_clk, in, 1, 400 MHz reservoir clock; all logic is on this clock.
- reset, in, 1, asynchronous, active-high reset.
- collect_dynamics, in, 1, arm strobe from the controller; a rising edge starts a capture.
- dynamics, in, 1, asynchronous reservoir node output.
- tx_ready, in, 1, UART TX can accept a byte.
- tx_byte, out, 8, byte presented to UART TX.
- tx_valid, out, 1, tx_byte is valid.
- busy, out, 1, high in CAPTURE or DRAIN.
- overflow, out, 1, sticky flag: at least one byte was dropped this run.

Behaviour:
- Reset (asynchronous, active-high, clock fast_clk) clears state, counters, FIFO and shift register.
  - Reset values: tx_byte=0, tx_valid=0, busy=0, overflow=0, state=IDLE.
  - Reset mid-run aborts the run; no partial byte is emitted.
- Input synchronisation:
  - `dynamics` passes through a 2-flop synchroniser before sampling; this adds 2 cycles of latency.
  - `collect_dynamics` is registered once for edge detection: rise = current & ~previous.
- State machine: IDLE -> CAPTURE -> DRAIN -> IDLE.
  - IDLE: on a rise of collect_dynamics, push HEADER into the FIFO, clear overflow, zero the bit and divider counters, then go to CAPTURE.
  - CAPTURE:
    - The divider counts 0..SAMPLE_DIV-1. At divider==0, shift the synchronised dynamics bit into the shift register, LSB first (first sample lands in bit 0).
    - On every 8th sample, push the completed byte into the FIFO in the same cycle the 8th bit is taken.
    - After NUM_SAMPLES samples, go to DRAIN.
    - The first sample is taken on the cycle after entering CAPTURE.
  - DRAIN: when the FIFO is empty and no tx_valid is outstanding, go to IDLE.
  - A rise of collect_dynamics during CAPTURE or DRAIN is ignored; no restart.
- busy = (state != IDLE).
- FIFO:
  - First-word fall-through. tx_valid = ~empty and tx_byte = head entry.
  - Pop when tx_valid & tx_ready.
  - Push when full:
    - Without a pop in the same cycle, the byte is dropped and overflow is set.
    - With a pop in the same cycle, the push succeeds.
  - Header push into a full FIFO follows the same rule.
  - Pointers are log2(FIFO_DEPTH)+1 bits and wrap naturally. Full = MSBs differ and the rest are equal.
- Handshake:
  - Once tx_valid is high, tx_byte is held stable until accepted.
  - tx_valid never drops without a pop.
  - tx_ready may be asserted at any time without effect while tx_valid=0.
- overflow stays set until the next capture start or reset.
- Bytes per run = 1 + NUM_SAMPLES/8.

Decomposition:
- Shared package (reservoir_pkg): state encoding (IDLE/CAPTURE/DRAIN), default HEADER constant, clog2 helper.
- One sub-module: sample_fifo (parameterised FWFT byte FIFO with push/pop/full/empty).
- The synchroniser, edge detect, divider, shifter and FSM stay in reservoir_sampler.

Test Plan:
- NUM_SAMPLES=16, SAMPLE_DIV=1, dynamics held 1, tx_ready=1, one collect pulse -> bytes A5, FF, FF; busy returns to 0; overflow=0.
- dynamics toggling every cycle (1,0,1,0… at sampler input after sync), NUM_SAMPLES=8 -> A5 then 55 (LSB first).
- SAMPLE_DIV=4, dynamics = 1 only on the sampled cycles, NUM_SAMPLES=8 -> A5, FF; capture lasts 32 cycles.
- tx_ready=0 throughout, FIFO_DEPTH=4, NUM_SAMPLES=64 -> exactly 4 bytes retained (A5 + first 3 data bytes); overflow=1; tx_byte held A5. Raise tx_ready -> 4 bytes drain, then IDLE.
- Second collect pulse mid-CAPTURE -> ignored; byte count unchanged (1+NUM_SAMPLES/8).
- Assert reset mid-CAPTURE after 12 samples -> tx_valid=0, busy=0 immediately; next collect gives a clean A5-headed frame.
